eth_tx_arbiter: RTL and testbench

- Shares the single byte-wide `mii_phy_encoder` transmit interface among NUM_REQ frame sources, e.g. the ARP responder and a debug/test frame generator.
- Arbitration is round-robin. The block reads each granted frame out of its requester's buffer through a shared read-address bus and streams it to the encoder.
- After each frame it enforces a minimum idle gap before granting the next frame.

---
 rtl/eth_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide encoder TX port among NUM_REQ frame buffers.
// Optional per-source frame and clamp counters under `TX_ARB_STATS_EN.
module eth_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int LEN_W      = 11,
    parameter int MAX_LEN    = 1514,
    parameter int IFG_CYCLES = 24
) (
    input  logic                     i_sys_clk,
    input  logic                     i_nreset,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_len,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [LEN_W-1:0]         o_rd_addr,
    input  logic [NUM_REQ*8-1:0]     i_rd_data,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     o_busy
`ifdef TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    o_frame_cnt,
    output logic [15:0]              o_drop_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(IFG_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   addr_q, addr_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [2*NUM_REQ-1:0] req_sh;
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic [LEN_W-1:0]     len_sel;
    logic                 len_big;
    logic [7:0]           rd_byte;
    int                   w;

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        req_sh = {i_req, i_req} >> ptr_q;
        found  = 1'b0;
        win    = '0;
        w      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_sh[k]) begin
                found = 1'b1;
                w     = int'(ptr_q) + k;
                if (w >= NUM_REQ) w = w - NUM_REQ;
                win   = PTR_W'(w);
            end
        end
        len_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (win == PTR_W'(k)) len_sel = i_len[k*LEN_W +: LEN_W];
        len_big = (len_sel > LEN_W'(MAX_LEN));
        rd_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt_q[k]) rd_byte = rd_byte | i_rd_data[k*8 +: 8];
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = (|done_q) ? '0 : gnt_q;
        done_d    = '0;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        tx_en_d   = 1'b0;
        tx_data_d = 8'h00;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                if (found && tx_ready) begin
                    for (int k = 0; k < NUM_REQ; k++) gnt_d[k] = (win == PTR_W'(k));
                    len_d   = len_big ? LEN_W'(MAX_LEN) : len_sel;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (len_q == '0) begin
                    done_d  = gnt_q;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    addr_d  = LEN_W'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Read data lags the address by one cycle, so byte cnt_q is on i_rd_data now.
                if (cnt_q != len_q) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = rd_byte;
                    addr_d    = addr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    done_d  = gnt_q;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (int'(gap_q) + 1 >= IFG_CYCLES) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_nreset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            ptr_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_done    = done_q;
    assign o_rd_addr = addr_q;
    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign o_busy    = (state_q != IDLE);

`ifdef TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] frame_q, frame_d;
    logic [15:0]              drop_q, drop_d;

    always_comb begin
        frame_d = frame_q;
        drop_d  = drop_q;
        for (int k = 0; k < NUM_REQ; k++)
            if (done_q[k] && len_q != '0 && frame_q[k] != 16'hFFFF)
                frame_d[k] = frame_q[k] + 16'd1;
        if (state_q == IDLE && found && tx_ready && len_big && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_nreset) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign o_frame_cnt = frame_q;
    assign o_drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: two sources, IFG_CYCLES=4, modelled one-cycle-latency buffers.
module tb_eth_tx_arbiter;

    localparam int NREQ = 2;
    localparam int LW   = 11;
    localparam int IFG  = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic [1:0]      req;
    logic [21:0]     len;
    logic [1:0]      gnt;
    logic [10:0]     rd_addr;
    logic [15:0]     rd_data;
    logic [1:0]      done;
    logic            tx_en_w;
    logic [7:0]      tx_data_w;
    logic            tx_ready;
    logic            busy;
`ifdef TX_ARB_STATS_EN
    logic [31:0]     frame_cnt;
    logic [15:0]     drop_cnt;
`endif

    eth_tx_arbiter #(.NUM_REQ(NREQ), .LEN_W(LW), .MAX_LEN(1514), .IFG_CYCLES(IFG)) dut (
        .i_sys_clk (clk),
        .i_nreset  (nreset),
        .i_req     (req),
        .i_len     (len),
        .o_gnt     (gnt),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_done    (done),
        .tx_en     (tx_en_w),
        .tx_data   (tx_data_w),
        .tx_ready  (tx_ready),
        .o_busy    (busy)
`ifdef TX_ARB_STATS_EN
        ,
        .o_frame_cnt (frame_cnt),
        .o_drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Source buffers: buffer0[a] = a[7:0], buffer1[a] = a[7:0] ^ 8'hA5.
    always @(posedge clk) rd_data <= {rd_addr[7:0] ^ 8'hA5, rd_addr[7:0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         gnt_cyc[$];
    logic [1:0] gnt_who[$];
    int         tx_cyc[$];
    logic [7:0] tx_byte[$];
    int         done_cyc[$];
    logic [1:0] done_who[$];
    logic [1:0] gnt_prev = 2'b00;

    always @(negedge clk) begin
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            gnt_cyc.push_back(cyc);
            gnt_who.push_back(gnt);
        end
        gnt_prev = gnt;
        if (tx_en_w === 1'b1) begin
            tx_cyc.push_back(cyc);
            tx_byte.push_back(tx_data_w);
        end
        if (done != 2'b00) begin
            done_cyc.push_back(cyc);
            done_who.push_back(done);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        gnt_cyc.delete(); gnt_who.delete();
        tx_cyc.delete();  tx_byte.delete();
        done_cyc.delete(); done_who.delete();
    endtask

    task automatic wait_done(input int n, input int bound, output bit to);
        to = 1'b1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cyc.size() >= n) begin
                req = 2'b00;
                to  = 1'b0;
                break;
            end
        end
        req = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) break;
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick(); tick();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; req = 2'b00; len = '0; tx_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00)
            $display("FAIL reset_gnt_done gnt=%b done=%b expected 00 00", gnt, done);
        else checks = checks;
        if (gnt !== 2'b00 || done !== 2'b00) errors++;
        checks++;
        if (tx_en_w !== 1'b0 || tx_data_w !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx tx_en=%b tx_data=%h expected 0 00", tx_en_w, tx_data_w);
        end
        checks++;
        if (rd_addr !== 11'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr_busy addr=%0d busy=%b expected 0 0", rd_addr, busy);
        end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit to; int t; bit bad;
        clear_log();
        len[10:0] = 11'd42; req = 2'b01;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (gnt_cyc.size() >= 2) begin to = 1'b0; break; end
        end
        wait_done(2, 200, to);
        checks++;
        if (to || gnt_cyc.size() < 2 || tx_cyc.size() != 84 || done_cyc.size() < 2) begin
            errors++;
            $display("FAIL single_count grants=%0d bytes=%0d dones=%0d expected 2 84 2",
                     gnt_cyc.size(), tx_cyc.size(), done_cyc.size());
            return;
        end
        t = gnt_cyc[0];
        checks++;
        if (gnt_who[0] !== 2'b01) begin
            errors++; $display("FAIL single_gnt got=%b expected 01", gnt_who[0]);
        end
        bad = 1'b0;
        for (int k = 0; k < 42; k++) if (tx_cyc[k] != t + 2 + k) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL single_tx_timing first=%0d last=%0d expected %0d %0d",
                     tx_cyc[0], tx_cyc[41], t + 2, t + 43);
        end
        bad = 1'b0;
        for (int k = 0; k < 42; k++)
            if (tx_byte[k] !== 8'(k) || tx_byte[42+k] !== 8'(k)) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL single_tx_data byte1=%h byte41=%h expected 01 29", tx_byte[1], tx_byte[41]);
        end
        checks++;
        if (done_cyc[0] != t + 44 || done_who[0] !== 2'b01) begin
            errors++;
            $display("FAIL single_done cyc=%0d who=%b expected %0d 01", done_cyc[0], done_who[0], t + 44);
        end
        checks++;
        if (gnt_cyc[1] < t + 49) begin
            errors++; $display("FAIL single_ifg next_gnt=%0d expected >=%0d", gnt_cyc[1], t + 49);
        end
        checks++;
        if (tx_cyc[42] - tx_cyc[41] < IFG + 3) begin
            errors++;
            $display("FAIL single_spacing got=%0d expected >=%0d", tx_cyc[42] - tx_cyc[41], IFG + 3);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        bit to; bit bad;
        logic [1:0] exp_who [4];
        exp_who[0] = 2'b01; exp_who[1] = 2'b10; exp_who[2] = 2'b01; exp_who[3] = 2'b10;
        do_reset();
        clear_log();
        len[10:0] = 11'd4; len[21:11] = 11'd4; req = 2'b11;
        wait_done(4, 300, to);
        checks++;
        if (to || gnt_cyc.size() != 4 || tx_cyc.size() != 16) begin
            errors++;
            $display("FAIL rr_count grants=%0d bytes=%0d expected 4 16", gnt_cyc.size(), tx_cyc.size());
            return;
        end
        bad = 1'b0;
        for (int f = 0; f < 4; f++) if (gnt_who[f] !== exp_who[f] || done_who[f] !== exp_who[f]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rr_order got=%b,%b,%b,%b expected 01,10,01,10",
                     gnt_who[0], gnt_who[1], gnt_who[2], gnt_who[3]);
        end
        bad = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 4; k++)
                if (tx_byte[4*f+k] !== (8'(k) ^ ((f % 2 == 1) ? 8'hA5 : 8'h00))) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rr_data f1b0=%h f2b3=%h expected a5 03", tx_byte[4], tx_byte[11]);
        end
        wait_idle();
    endtask

    task automatic test_tx_ready();
        bit to; int c;
        clear_log();
        tx_ready = 1'b0; len[21:11] = 11'd3; req = 2'b10;
        repeat (6) tick();
        checks++;
        if (gnt_cyc.size() != 0 || busy !== 1'b0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL ready_hold grants=%0d busy=%b gnt=%b expected 0 0 00", gnt_cyc.size(), busy, gnt);
        end
        tx_ready = 1'b1;
        c = cyc;
        tick();
        tx_ready = 1'b0;
        checks++;
        if (gnt_cyc.size() != 1 || gnt !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_grant grants=%0d gnt=%b busy=%b expected 1 10 1", gnt_cyc.size(), gnt, busy);
        end else if (gnt_cyc[0] != c + 1) begin
            errors++;
            $display("FAIL ready_grant cyc=%0d expected %0d", gnt_cyc[0], c + 1);
        end
        wait_done(1, 50, to);
        checks++;
        if (to || tx_byte.size() != 3 || tx_byte[0] !== 8'hA5 || tx_byte[1] !== 8'hA4 || tx_byte[2] !== 8'hA7) begin
            errors++;
            $display("FAIL ready_frame bytes=%0d b0=%h expected 3 a5", tx_byte.size(),
                     (tx_byte.size() > 0) ? tx_byte[0] : 8'h00);
        end
        tx_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_zero_len();
        bit to; int t;
`ifdef TX_ARB_STATS_EN
        logic [15:0] fc0;
        fc0 = frame_cnt[15:0];
`endif
        clear_log();
        len[10:0] = 11'd0; req = 2'b01;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt_cyc.size() >= 2) begin to = 1'b0; break; end
        end
        wait_done(2, 50, to);
        checks++;
        if (to || gnt_cyc.size() < 2 || done_cyc.size() < 2) begin
            errors++;
            $display("FAIL zero_count grants=%0d dones=%0d expected 2 2", gnt_cyc.size(), done_cyc.size());
            return;
        end
        t = gnt_cyc[0];
        checks++;
        if (done_cyc[0] != t + 1 || done_who[0] !== 2'b01) begin
            errors++;
            $display("FAIL zero_done cyc=%0d who=%b expected %0d 01", done_cyc[0], done_who[0], t + 1);
        end
        checks++;
        if (tx_cyc.size() != 0) begin
            errors++; $display("FAIL zero_tx bytes=%0d expected 0", tx_cyc.size());
        end
        checks++;
        if (gnt_cyc[1] < t + 1 + IFG) begin
            errors++; $display("FAIL zero_gap next_gnt=%0d expected >=%0d", gnt_cyc[1], t + 1 + IFG);
        end
`ifdef TX_ARB_STATS_EN
        checks++;
        if (frame_cnt[15:0] !== fc0) begin
            errors++; $display("FAIL zero_stats frame_cnt0=%0d expected %0d", frame_cnt[15:0], fc0);
        end
`endif
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_log();
        len[10:0] = 11'd60; req = 2'b01;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_cyc.size() >= 20) break;
        end
        checks++;
        if (tx_en_w !== 1'b1) begin
            errors++; $display("FAIL midreset_pre tx_en=%b expected 1", tx_en_w);
        end
        nreset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (tx_en_w !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0 || tx_data_w !== 8'h00 || done !== 2'b00) begin
            errors++;
            $display("FAIL midreset tx_en=%b gnt=%b busy=%b tx_data=%h done=%b expected 0 00 0 00 00",
                     tx_en_w, gnt, busy, tx_data_w, done);
        end
        tick();
        clear_log();
        len[10:0] = 11'd4; len[21:11] = 11'd4; req = 2'b11;
        nreset = 1'b1;
        wait_done(2, 100, to);
        checks++;
        if (to || gnt_who.size() < 2 || gnt_who[0] !== 2'b01 || gnt_who[1] !== 2'b10) begin
            errors++;
            $display("FAIL midreset_prio grants=%0d first=%b expected 2 01", gnt_who.size(),
                     (gnt_who.size() > 0) ? gnt_who[0] : 2'b00);
        end
        wait_idle();
    endtask

    task automatic test_clamp();
        bit to; bit bad;
        do_reset();
        clear_log();
        len[10:0] = 11'd2000; req = 2'b01;
        wait_done(1, 1700, to);
        checks++;
        if (to || tx_byte.size() != 1514) begin
            errors++; $display("FAIL clamp_len bytes=%0d expected 1514", tx_byte.size());
        end else begin
            bad = 1'b0;
            for (int k = 0; k < 1514; k++) if (tx_byte[k] !== 8'(k)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL clamp_data last=%h expected e9", tx_byte[1513]);
            end
        end
        tick();
`ifdef TX_ARB_STATS_EN
        checks++;
        if (drop_cnt !== 16'd1 || frame_cnt[15:0] !== 16'd1 || frame_cnt[31:16] !== 16'd0) begin
            errors++;
            $display("FAIL clamp_stats drop=%0d frame0=%0d frame1=%0d expected 1 1 0",
                     drop_cnt, frame_cnt[15:0], frame_cnt[31:16]);
        end
`endif
        wait_idle();
    endtask

    initial begin
        nreset = 1'b0; req = 2'b00; len = '0; tx_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_tx_ready();
        test_zero_len();
        test_reset_mid();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
